// File: rtl/hwag_pkg.sv
// Shared definitions for the hardware angle generator and its downstream blocks.
//   ACNT_WIDTH  - width of the angle counter (ACNT2) and of all angle registers
//   HWAMAXACR   - last angle count of a revolution; the counter wraps HWAMAXACR -> 0
//   ch_angles_t - set/reset angle pair of one output channel
//   wr_sel_e    - write-port selector: which angle of a channel a write targets
package hwag_pkg;

  localparam int unsigned ACNT_WIDTH = 24;
  localparam logic [ACNT_WIDTH-1:0] HWAMAXACR = 24'd3839;

  typedef struct packed {
    logic [ACNT_WIDTH-1:0] set_angle;
    logic [ACNT_WIDTH-1:0] reset_angle;
  } ch_angles_t;

  typedef enum logic {
    WrSetAngle   = 1'b0,
    WrResetAngle = 1'b1
  } wr_sel_e;

endpackage

// File: rtl/hwag_ch_unit.sv
// One angle-driven output channel.
// Holds the active set/reset angles (plus shadow copies when HWAG_CH_SHADOW_EN is defined),
// compares them against the live angle on generator steps and keeps the one-bit channel state.
//
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   hwag_start  - generator synchronised; low forces the channel OFF
//   step        - acnt moved to a new value this cycle (qualified by sync)
//   load_act    - copy shadow -> active (wrap or sync rise); unused without shadow registers
//   acnt        - current angle counter value
//   ena         - channel enable; low forces the channel OFF
//   wr_hit      - validated write addressed to this channel
//   wr_sel      - 0 = set angle, 1 = reset angle
//   wr_data     - angle value to write
//   ch_out      - registered channel output
//
// Build option: HWAG_CH_SHADOW_EN selects shadow-buffered angle updates.
module hwag_ch_unit #(
  parameter int unsigned AngleWidth = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic                  step,
  input  logic                  load_act,
  input  logic [AngleWidth-1:0] acnt,
  input  logic                  ena,
  input  logic                  wr_hit,
  input  logic                  wr_sel,
  input  logic [AngleWidth-1:0] wr_data,
  output logic                  ch_out
);
  import hwag_pkg::*;

  logic [AngleWidth-1:0] set_act_q;
  logic [AngleWidth-1:0] rst_act_q;
  logic                  wr_set;
  logic                  wr_rst;
  logic                  state_q;
  logic                  state_d;

  assign wr_set = wr_hit & (wr_sel_e'(wr_sel) == WrSetAngle);
  assign wr_rst = wr_hit & (wr_sel_e'(wr_sel) == WrResetAngle);

`ifdef HWAG_CH_SHADOW_EN
  logic [AngleWidth-1:0] set_sh_q;
  logic [AngleWidth-1:0] rst_sh_q;

  // A write landing in the load cycle goes to shadow only; active takes the pre-write shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_sh_q  <= '0;
      rst_sh_q  <= '0;
      set_act_q <= '0;
      rst_act_q <= '0;
    end else begin
      if (wr_set) set_sh_q <= wr_data;
      if (wr_rst) rst_sh_q <= wr_data;
      if (load_act) begin
        set_act_q <= set_sh_q;
        rst_act_q <= rst_sh_q;
      end
    end
  end
`else
  logic unused_load_act;
  assign unused_load_act = load_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_act_q <= '0;
      rst_act_q <= '0;
    end else begin
      if (wr_set) set_act_q <= wr_data;
      if (wr_rst) rst_act_q <= wr_data;
    end
  end
`endif

  // Reset angle is tested first so set == reset leaves the channel OFF.
  always_comb begin
    state_d = state_q;
    if (!hwag_start || !ena) begin
      state_d = 1'b0;
    end else if (step && (acnt == rst_act_q)) begin
      state_d = 1'b0;
    end else if (step && (acnt == set_act_q)) begin
      state_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign ch_out = state_q;

endmodule

// File: rtl/hwag_angle_channels.sv
// Angle-driven output channel bank downstream of the hardware angle generator.
// Tracks the generator angle counter, detects steps and revolution wraps, validates writes
// to the per-channel angle registers and drives CH_NUM registered outputs.
//
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   hwag_start  - generator synchronised; low = angle invalid, all channels OFF
//   acnt        - current angle counter (0..MAXACR)
//   ch_ena      - per-channel enable
//   wr_en       - single-cycle write strobe
//   wr_addr     - channel index of the write
//   wr_sel      - 0 = set angle, 1 = reset angle
//   wr_data     - angle value
//   wr_err      - one-cycle pulse after a rejected write
//   rev_pulse   - one-cycle pulse after a revolution wrap
//   ch_out      - channel outputs
//
// Build option: HWAG_CH_SHADOW_EN buffers angle writes in shadow registers that become active
// at a wrap or on a hwag_start rise; without it writes update the active angles directly.
module hwag_angle_channels #(
  parameter int unsigned            ACNT_WIDTH = hwag_pkg::ACNT_WIDTH,
  parameter int unsigned            CH_NUM     = 4,
  parameter logic [ACNT_WIDTH-1:0]  MAXACR     = hwag_pkg::HWAMAXACR,
  localparam int unsigned           ADDR_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic [CH_NUM-1:0]     ch_ena,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  wr_sel,
  input  logic [ACNT_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  output logic                  rev_pulse,
  output logic [CH_NUM-1:0]     ch_out
);

  localparam logic [ADDR_W:0] ChNumW = CH_NUM[ADDR_W:0];

  logic [ACNT_WIDTH-1:0] acnt_q;
  logic                  sync_q;
  logic                  rev_pulse_q;
  logic                  wr_err_q;
  logic                  step;
  logic                  wrap;
  logic                  rise;
  logic                  addr_bad;
  logic                  wr_bad;
  logic                  wr_ok;

  // sync_q gates steps so the first synchronised cycle only loads acnt_q.
  assign step     = hwag_start & sync_q & (acnt != acnt_q);
  assign wrap     = step & (acnt == '0) & (acnt_q == MAXACR);
  assign rise     = hwag_start & ~sync_q;

  assign addr_bad = ({1'b0, wr_addr} >= ChNumW);
  assign wr_bad   = (wr_data > MAXACR) | addr_bad;
  assign wr_ok    = wr_en & ~wr_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acnt_q      <= '0;
      sync_q      <= 1'b0;
      rev_pulse_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      acnt_q      <= acnt;
      sync_q      <= hwag_start;
      rev_pulse_q <= wrap;
      wr_err_q    <= wr_en & wr_bad;
    end
  end

  assign rev_pulse = rev_pulse_q;
  assign wr_err    = wr_err_q;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = wr_ok & (wr_addr == ADDR_W'(i));

    hwag_ch_unit #(
      .AngleWidth (ACNT_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .hwag_start (hwag_start),
      .step       (step),
      .load_act   (wrap | rise),
      .acnt       (acnt),
      .ena        (ch_ena[i]),
      .wr_hit     (wr_hit),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .ch_out     (ch_out[i])
    );
  end

endmodule

// File: tb/tb_hwag_angle_channels.sv
// Self-checking bench for hwag_angle_channels. Three channels are used so that an
// out-of-range channel index (3) is expressible on the 2-bit write address.
module tb_hwag_angle_channels;

  localparam int CHN  = 3;
  localparam int MAXA = 3839;
`ifdef HWAG_CH_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hwag_start;
  logic [23:0] acnt;
  logic [2:0]  ch_ena;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic        wr_sel;
  logic [23:0] wr_data;
  logic        wr_err;
  logic        rev_pulse;
  logic [2:0]  ch_out;

  int checks = 0;
  int errors = 0;

  hwag_angle_channels #(
    .ACNT_WIDTH (24),
    .CH_NUM     (CHN),
    .MAXACR     (24'd3839)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .acnt       (acnt),
    .ch_ena     (ch_ena),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .rev_pulse  (rev_pulse),
    .ch_out     (ch_out)
  );

  always #5 clk = ~clk;

  // Reference model: angle tables and expected outputs after each clock edge.
  int         m_set[CHN];
  int         m_rst[CHN];
  int         m_sset[CHN];
  int         m_srst[CHN];
  logic [2:0] m_ch;
  int         m_prev;
  bit         m_sync;
  bit         m_rev;
  bit         m_err;

  task automatic model_reset();
    for (int i = 0; i < CHN; i++) begin
      m_set[i] = 0; m_rst[i] = 0; m_sset[i] = 0; m_srst[i] = 0;
    end
    m_ch = '0; m_prev = 0; m_sync = 0; m_rev = 0; m_err = 0;
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit stp, wrp, rise, bad;
    int a;
    a    = int'(acnt);
    stp  = hwag_start && m_sync && (a != m_prev);
    wrp  = stp && (a == 0) && (m_prev == MAXA);
    rise = hwag_start && !m_sync;
    bad  = wr_en && ((int'(wr_data) > MAXA) || (int'(wr_addr) >= CHN));
    for (int i = 0; i < CHN; i++) begin
      if (!hwag_start || !ch_ena[i]) m_ch[i] = 1'b0;
      else if (stp && a == m_rst[i]) m_ch[i] = 1'b0;
      else if (stp && a == m_set[i]) m_ch[i] = 1'b1;
    end
    if (SHADOW && (wrp || rise)) begin
      for (int i = 0; i < CHN; i++) begin
        m_set[i] = m_sset[i];
        m_rst[i] = m_srst[i];
      end
    end
    if (wr_en && !bad) begin
      if (SHADOW) begin
        if (wr_sel) m_srst[wr_addr] = int'(wr_data);
        else        m_sset[wr_addr] = int'(wr_data);
      end else begin
        if (wr_sel) m_rst[wr_addr] = int'(wr_data);
        else        m_set[wr_addr] = int'(wr_data);
      end
    end
    m_rev  = wrp;
    m_err  = bad;
    m_prev = a;
    m_sync = hwag_start;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input bit sel, input int val);
    wr_en   = 1'b1;
    wr_addr = 2'(ch);
    wr_sel  = sel;
    wr_data = 24'(val);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (ch_out !== 3'b000 || wr_err !== 1'b0 || rev_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ch_out=%b wr_err=%b rev=%b want 000 0 0",
               ch_out, wr_err, rev_pulse);
    end
    @(posedge clk);
    #1;
    rst    = 1'b1;
    ch_ena = 3'b111;
  endtask

  task automatic test_basic();
    int revs = 0;
    wr(0, 1'b0, 100);
    wr(0, 1'b1, 200);
    acnt = 24'd0;
    hwag_start = 1'b1;
    tick();
    for (int k = 1; k <= MAXA + 121; k++) begin
      int a;
      a = k % (MAXA + 1);
      acnt    = 24'(a);
      // Mid-revolution write: shadow builds defer it to the wrap.
      wr_en   = (k == 1000);
      wr_addr = 2'd0;
      wr_sel  = 1'b0;
      wr_data = 24'd1500;
      tick();
      wr_en = 1'b0;
      if (rev_pulse) revs++;
      checks++;
      if (ch_out !== m_ch || rev_pulse !== m_rev || wr_err !== m_err) begin
        errors++;
        $display("FAIL basic_model acnt=%0d got ch=%b rev=%b err=%b want ch=%b rev=%b err=%b",
                 a, ch_out, rev_pulse, wr_err, m_ch, m_rev, m_err);
      end
      if (k == 99 || k == 100 || k == 199 || k == 200) begin
        checks++;
        if (ch_out[0] !== ((k == 100 || k == 199) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL basic_edge acnt=%0d got ch0=%b", a, ch_out[0]);
        end
      end
      if (k == MAXA + 1) begin
        checks++;
        if (rev_pulse !== 1'b1) begin
          errors++;
          $display("FAIL basic_rev_at_wrap got %b want 1", rev_pulse);
        end
      end
    end
    checks++;
    if (revs != 1) begin
      errors++;
      $display("FAIL basic_rev_count got %0d want 1", revs);
    end
  endtask

  task automatic test_wrap_straddle();
    hwag_start = 1'b0;
    tick();
    wr(1, 1'b0, 3800);
    wr(1, 1'b1, 50);
    acnt = 24'd3790;
    hwag_start = 1'b1;
    tick();
    for (int k = 1; k <= 110; k++) begin
      int a;
      bit exp1;
      a    = (3790 + k) % (MAXA + 1);
      exp1 = (a >= 3800) || (a < 50);
      acnt = 24'(a);
      tick();
      checks++;
      if (ch_out[1] !== exp1 || ch_out !== m_ch || rev_pulse !== m_rev) begin
        errors++;
        $display("FAIL straddle acnt=%0d got ch=%b rev=%b want ch1=%b model ch=%b rev=%b",
                 a, ch_out, rev_pulse, exp1, m_ch, m_rev);
      end
    end
  endtask

  task automatic test_jump();
    hwag_start = 1'b0;
    tick();
    wr(0, 1'b0, 100);
    wr(0, 1'b1, 200);
    acnt = 24'd80;
    hwag_start = 1'b1;
    tick();
    acnt = 24'd90;
    tick();
    acnt = 24'd150;
    tick();
    checks++;
    if (ch_out[0] !== 1'b0 || ch_out !== m_ch) begin
      errors++;
      $display("FAIL jump_over_set got ch=%b want ch0=0 model %b", ch_out, m_ch);
    end
    acnt = 24'd200;
    tick();
    checks++;
    if (ch_out[0] !== 1'b0 || ch_out !== m_ch) begin
      errors++;
      $display("FAIL jump_reset_step got ch=%b want ch0=0 model %b", ch_out, m_ch);
    end
  endtask

  task automatic test_invalid_write();
    wr(0, 1'b0, 3840);
    checks++;
    if (wr_err !== 1'b1 || m_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_data_err got %b want 1", wr_err);
    end
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_data_pulse got %b want 0", wr_err);
    end
    wr(3, 1'b1, 10);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_err got %b want 1", wr_err);
    end
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_pulse got %b want 0", wr_err);
    end
    // Angles must be untouched: ch0 still fires at 100.
    hwag_start = 1'b0;
    tick();
    acnt = 24'd95;
    hwag_start = 1'b1;
    tick();
    for (int a = 96; a <= 105; a++) begin
      acnt = 24'(a);
      tick();
      checks++;
      if (ch_out[0] !== ((a >= 100) ? 1'b1 : 1'b0) || ch_out !== m_ch) begin
        errors++;
        $display("FAIL bad_write_kept acnt=%0d got ch=%b model %b", a, ch_out, m_ch);
      end
    end
    wr(2, 1'b0, 300);
    wr(2, 1'b1, 300);
    hwag_start = 1'b0;
    tick();
    acnt = 24'd295;
    hwag_start = 1'b1;
    tick();
    for (int a = 296; a <= 305; a++) begin
      acnt = 24'(a);
      tick();
      checks++;
      if (ch_out[2] !== 1'b0 || ch_out !== m_ch) begin
        errors++;
        $display("FAIL set_eq_reset acnt=%0d got ch=%b model %b", a, ch_out, m_ch);
      end
    end
  endtask

  task automatic test_sync_loss();
    hwag_start = 1'b0;
    tick();
    acnt = 24'd98;
    hwag_start = 1'b1;
    tick();
    for (int a = 99; a <= 150; a++) begin
      acnt = 24'(a);
      tick();
    end
    checks++;
    if (ch_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL sync_window got ch0=%b want 1", ch_out[0]);
    end
    hwag_start = 1'b0;
    tick();
    checks++;
    if (ch_out !== 3'b000) begin
      errors++;
      $display("FAIL sync_drop got ch=%b want 000", ch_out);
    end
    acnt = 24'd100;
    hwag_start = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (ch_out[0] !== 1'b0) begin
        errors++;
        $display("FAIL sync_rise_stale cycle=%0d got ch0=%b want 0", n, ch_out[0]);
      end
    end
    acnt = 24'd99;
    tick();
    acnt = 24'd100;
    tick();
    checks++;
    if (ch_out[0] !== 1'b1 || ch_out !== m_ch) begin
      errors++;
      $display("FAIL sync_genuine_step got ch=%b want ch0=1 model %b", ch_out, m_ch);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ch_out !== 3'b000 || rev_pulse !== 1'b0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got ch=%b rev=%b err=%b want 000 0 0",
               ch_out, rev_pulse, wr_err);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    ch_ena     = 3'b111;
    acnt       = 24'd3839;
    hwag_start = 1'b1;
    tick();
    acnt = 24'd0;
    tick();
    checks++;
    if (ch_out !== 3'b000 || rev_pulse !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_angles got ch=%b rev=%b want 000 1", ch_out, rev_pulse);
    end
    acnt = 24'd1;
    tick();
    checks++;
    if (ch_out !== 3'b000 || rev_pulse !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_step got ch=%b rev=%b want 000 0", ch_out, rev_pulse);
    end
  endtask

  task automatic test_random();
    hwag_start = 1'b1;
    ch_ena     = 3'b111;
    for (int n = 0; n < 12000; n++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 30)      acnt = 24'($urandom_range(0, MAXA));
      else if (r >= 80) acnt = (int'(acnt) == MAXA) ? 24'd0 : acnt + 24'd1;
      if (hwag_start && $urandom_range(0, 999) < 3) hwag_start = 1'b0;
      else if (!hwag_start && $urandom_range(0, 999) < 200) hwag_start = 1'b1;
      if ($urandom_range(0, 999) < 3) ch_ena[$urandom_range(0, 2)] ^= 1'b1;
      wr_en = ($urandom_range(0, 99) < 3);
      if (wr_en) begin
        wr_addr = 2'($urandom_range(0, 3));
        wr_sel  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0)
          wr_data = 24'(MAXA + 1 + int'($urandom_range(0, 5)));
        else
          wr_data = 24'((int'(acnt) + int'($urandom_range(1, 300))) % (MAXA + 1));
      end
      tick();
      wr_en = 1'b0;
      checks++;
      if (ch_out !== m_ch || rev_pulse !== m_rev || wr_err !== m_err) begin
        errors++;
        $display("FAIL random n=%0d acnt=%0d got ch=%b rev=%b err=%b want ch=%b rev=%b err=%b",
                 n, acnt, ch_out, rev_pulse, wr_err, m_ch, m_rev, m_err);
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    hwag_start = 1'b0;
    acnt       = '0;
    ch_ena     = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_sel     = 1'b0;
    wr_data    = '0;
    model_reset();
    test_reset();
    test_basic();
    test_wrap_straddle();
    test_jump();
    test_invalid_write();
    test_sync_loss();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwag_angle_channels.md
# hwag_angle_channels

Angle-driven output channel bank sitting directly downstream of the hardware angle generator. It consumes the generator's angle counter (ACNT2, 0..HWAMAXACR) and its start/sync flag. It drives CH_NUM digital outputs (ignition/injection style), each set and cleared at a programmed crank angle. Angles are programmed through a simple single-cycle write port and, by default, applied through shadow registers at the revolution boundary.

## Interface
Parameters:
- ACNT_WIDTH, 24: width of the angle counter and angle registers.
- CH_NUM, 4: number of output channels (1..16).
- MAXACR, 24'd3839: maximum angle count; the counter wraps MAXACR -> 0.

Ports:
- clk  input  1: system clock (single clock domain).
- rst  input  1: asynchronous reset, active-low.
- hwag_start  input  1: generator synchronised; low = angle invalid.
- acnt  input  ACNT_WIDTH: current angle counter value.
- ch_ena  input  CH_NUM: per-channel enable (static/quasi-static).
- wr_en  input  1: write strobe, one cycle.
- wr_addr  input  $clog2(CH_NUM) (min 1): channel index.
- wr_sel  input  1: 0 = set angle, 1 = reset angle.
- wr_data  input  ACNT_WIDTH: angle value.
- wr_err  output  1: one-cycle pulse when a write is rejected.
- rev_pulse  output  1: one-cycle pulse on revolution wrap.
- ch_out  output  CH_NUM: channel outputs.

## Operation
- Reset (rst low): ch_out=0, wr_err=0, rev_pulse=0, acnt_q=0, all set/reset angles (active and shadow) = 0, sync flag = 0.
- acnt is sampled into acnt_q every cycle. A step is a cycle with hwag_start=1 and acnt != acnt_q.
- Wrap: a step with acnt==0 and acnt_q==MAXACR. On a wrap, rev_pulse is asserted for one cycle.
- Per-channel state machine, one state bit:
  - OFF -> ON on a step with acnt==set_angle and ch_ena[i]=1.
  - ON -> OFF on a step with acnt==reset_angle, or when ch_ena[i]=0.
- Equality is checked only on steps, so jumps in acnt (resync loads) never fire an intermediate angle.
- set_angle==reset_angle: reset wins and the channel stays OFF.
- Set and reset windows may straddle the wrap (set > reset is legal). Wrap-around needs no special handling.
- hwag_start=0: all channels forced OFF and no steps are recognised.
- hwag_start 0->1: the first cycle only loads acnt_q and generates no step, so a stale acnt cannot fire a channel.
- Writes:
  - wr_data > MAXACR, or wr_addr >= CH_NUM: write ignored and wr_err pulses the next cycle.
  - Otherwise the value goes to the shadow (or active) register of the selected channel and angle type.
- Write in the same cycle as a matching step: the step compares against the old active value.

## Timing
- Latency: ch_out changes on the clock edge that ends the first cycle in which the new acnt is present with hwag_start=1. Output is visible 1 cycle after acnt changes.
- rev_pulse is aligned with that same edge.
- wr_err is asserted 1 cycle after the rejected wr_en.
- Shadow -> active copy happens on the wrap edge. Channel comparisons in that wrap cycle use the pre-copy active values. A write in the wrap cycle lands in shadow and is applied on the next wrap.
- Shadow -> active copy also happens on the hwag_start 0->1 edge.
- Outputs are registered and glitch-free. Reset asserted mid-operation clears everything immediately (asynchronously).

## Configuration
- HWAG_CH_SHADOW_EN defined: writes go to shadow registers and become active only at a wrap or at a hwag_start rise (behaviour described above).
- HWAG_CH_SHADOW_EN undefined: shadow registers are not built. Writes update the active registers at the write edge and take effect from the next cycle's comparison.

## Structure
- Shared package hwag_pkg holds:
  - ACNT_WIDTH and HWAMAXACR constants, shared with the generator.
  - A typedef struct {set_angle, reset_angle} for channel angles.
  - A typedef for the write-select encoding.
- One sub-module, hwag_ch_unit, instantiated CH_NUM times. It holds the active/shadow registers, equality compares and state bit for one channel.
- The top level owns acnt_q, step and wrap detection, write decode and the error pulse.

## Test plan
- Programming and basic cycle: ch0 set=100, reset=200 (shadow on), then one full revolution stepping acnt 0..3839. Required:
  - ch_out[0] rises 1 cycle after acnt=100 and falls 1 cycle after acnt=200.
  - Active values apply only after the first wrap.
  - rev_pulse is seen once per wrap.
- Wrap straddle: ch1 set=3800, reset=50. ch_out[1] is high from acnt 3800 through the wrap until 1 cycle after acnt=50.
- Jump immunity: acnt jumps 90 -> 150 with set=100. ch_out does not rise. A step with acnt=200 and reset=200 keeps the channel OFF.
- Invalid write: wr_data=3840, and separately wr_addr=CH_NUM (with CH_NUM=4, wr_addr=4 needs the index widened in the bench). Each produces a wr_err one-cycle pulse and leaves the registers unchanged. set==reset=300 leaves the channel OFF.
- Sync loss: hwag_start drops while ch_out[0]=1, so ch_out becomes 0 next cycle. On hwag_start rise with acnt=100==set, no firing occurs until the next genuine step to 100.
- Async reset mid-window: rst low while channels are ON clears ch_out immediately. After rst is released, all angles read back as 0, so a step to acnt=0 with set=reset=0 keeps outputs OFF.
